// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode / write-back stage.
// 15 x 64-bit register file, combinational reads, clocked commits, sticky halt.
`timescale 1ns/10ps
module decode_writeback #(
    parameter logic [63:0] STACK_INIT = 64'd512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        condition,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic        halted,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] dbg_data
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [63:0] regs [0:14];
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic        stop;

    // Register selects derived from the instruction code.
    always_comb begin
        srca = RNONE;
        srcb = RNONE;
        dste = RNONE;
        dstm = RNONE;
        stop = 1'b0;
        case (icode)
            4'h0: stop = 1'b1;
            4'h1: ;
            4'h2: begin
                srca = rA;
                dste = condition ? rB : RNONE;
            end
            4'h3: dste = rB;
            4'h4: begin
                srca = rA;
                srcb = rB;
            end
            4'h5: begin
                srcb = rB;
                dstm = rA;
            end
            4'h6: begin
                srca = rA;
                srcb = rB;
                dste = rB;
            end
            4'h7: ;
            4'h8: begin
                srcb = RSP;
                dste = RSP;
            end
            4'h9: begin
                srca = RSP;
                srcb = RSP;
                dste = RSP;
            end
            4'hA: begin
                srca = rA;
                srcb = RSP;
                dste = RSP;
            end
            4'hB: begin
                srca = RSP;
                srcb = RSP;
                dste = RSP;
                dstm = rA;
            end
            default: stop = 1'b1;
        endcase
    end

    assign valA     = (srca == RNONE) ? 64'd0 : regs[srca];
    assign valB     = (srcb == RNONE) ? 64'd0 : regs[srcb];
    assign dbg_data = (dbg_addr == RNONE) ? 64'd0 : regs[dbg_addr];

    // Commit write-back; memory result beats ALU result on a shared target.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (4'(i) == RSP) ? STACK_INIT : 64'd0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (stop) begin
                halted <= 1'b1;
            end else begin
                for (int i = 0; i < 15; i++) begin
                    if (dstm == 4'(i))
                        regs[i] <= valM;
                    else if (dste == 4'(i))
                        regs[i] <= valE;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed plan steps plus random traffic
// compared against an array-based behavioural model.
`timescale 1ns/10ps
module tb_decode_writeback;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        condition;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        halted;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;

    int total = 0;
    int bad = 0;

    logic [63:0] m [0:15];
    logic        mh;

    decode_writeback #(.STACK_INIT(64'd512)) dut (
        .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB),
        .valE(valE), .valM(valM), .condition(condition),
        .valA(valA), .valB(valB), .halted(halted),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] f_srca(input logic [3:0] ic,
                                          input logic [3:0] a);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_srcb(input logic [3:0] ic,
                                          input logic [3:0] b);
        if (ic inside {4'h4, 4'h5, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dste(input logic [3:0] ic,
                                          input logic [3:0] b,
                                          input logic c);
        if (ic == 4'h2) return c ? b : 4'hF;
        if (ic inside {4'h3, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dstm(input logic [3:0] ic,
                                          input logic [3:0] a);
        if (ic inside {4'h5, 4'hB}) return a;
        return 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 64'd0;
        m[4] = 64'd512;
        mh = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] de;
        logic [3:0] dm;
        if (rst) begin
            model_reset();
        end else if (!mh) begin
            if (icode == 4'h0 || icode > 4'hB) begin
                mh = 1'b1;
            end else begin
                de = f_dste(icode, rB, condition);
                dm = f_dstm(icode, rA);
                if (de != 4'hF) m[de] = valE;
                if (dm != 4'hF) m[dm] = valM;
            end
        end
    endtask

    task automatic sweep();
        chk("halted_post", {63'd0, halted}, {63'd0, mh});
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #0.4;
            chk($sformatf("dbg%0d", i), dbg_data, m[i]);
        end
    endtask

    task automatic peek(input string tag, input logic [3:0] a,
                        input logic [63:0] exp);
        dbg_addr = a;
        #0.4;
        chk(tag, dbg_data, exp);
    endtask

    task automatic step(input logic r, input logic [3:0] ic,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [63:0] e, input logic [63:0] mv,
                        input logic c);
        rst = r;
        icode = ic;
        rA = a;
        rB = b;
        valE = e;
        valM = mv;
        condition = c;
        @(negedge clk);
        chk("valA", valA, m[f_srca(ic, a)]);
        chk("valB", valB, m[f_srcb(ic, b)]);
        chk("halted_pre", {63'd0, halted}, {63'd0, mh});
        @(posedge clk);
        model_edge();
        #1;
        sweep();
    endtask

    initial begin
        m[15] = 64'd0;
        rst = 1'b1;
        icode = 4'h1;
        rA = 4'hF;
        rB = 4'hF;
        valE = '0;
        valM = '0;
        condition = 1'b0;
        dbg_addr = 4'h0;
        @(posedge clk);
        model_reset();
        #1;
        sweep();
        peek("rst_rsp", 4'h4, 64'd512);

        step(0, 4'h3, 4'hF, 4'h2, 64'h1234, 64'h0, 0);
        peek("irmov_r2", 4'h2, 64'h1234);
        rst = 0; icode = 4'h6; rA = 4'h2; rB = 4'h2;
        #1;
        chk("opq_valA", valA, 64'h1234);
        chk("opq_valB", valB, 64'h1234);

        model_reset();
        step(1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 0);
        step(0, 4'h3, 4'hF, 4'h2, 64'h1234, 64'h0, 0);
        step(0, 4'h2, 4'h2, 4'h3, 64'd7, 64'h0, 0);
        peek("cmov_nc", 4'h3, 64'd0);
        step(0, 4'h2, 4'h2, 4'h3, 64'd7, 64'h0, 1);
        peek("cmov_c", 4'h3, 64'd7);

        rst = 0; icode = 4'hB; rA = 4'h4; rB = 4'hF;
        #1;
        chk("pop_valA_pre", valA, 64'd512);
        chk("pop_valB_pre", valB, 64'd512);
        step(0, 4'hB, 4'h4, 4'hF, 64'd520, 64'hDEAD, 0);
        peek("pop_rsp", 4'h4, 64'hDEAD);
        step(0, 4'hA, 4'h2, 4'hF, 64'd504, 64'h0, 0);
        peek("push_rsp", 4'h4, 64'd504);

        step(0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 0);
        chk("halt_set", {63'd0, halted}, 64'd1);
        for (int k = 0; k < 3; k++)
            step(0, 4'h3, 4'hF, 4'h1, 64'd99, 64'h0, 0);
        peek("halt_r1", 4'h1, 64'd0);
        step(1, 4'h3, 4'hF, 4'h1, 64'd99, 64'h0, 0);
        chk("rst_clr", {63'd0, halted}, 64'd0);
        peek("rst_r2", 4'h2, 64'd0);
        step(0, 4'hC, 4'hF, 4'hF, 64'h0, 64'h0, 0);
        chk("inv_halt", {63'd0, halted}, 64'd1);
        step(1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 0);

        step(0, 4'h3, 4'hF, 4'hF, 64'd5, 64'h0, 0);
        rst = 0; icode = 4'h1; rA = 4'h2; rB = 4'h3;
        #1;
        chk("nop_valA", valA, 64'd0);
        chk("nop_valB", valB, 64'd0);

        for (int n = 0; n < 400; n++) begin
            logic r;
            logic [3:0] ic;
            r = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0)
                ic = ($urandom_range(0, 1) == 0) ? 4'h0
                     : 4'($urandom_range(12, 15));
            else
                ic = 4'($urandom_range(1, 11));
            step(r, ic, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)));
            if (mh && $urandom_range(0, 3) == 0)
                step(1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
